// File: rtl/balance_pid_seq.sv
// balance_pid_seq: sequences one PID update per pitch sample on a shared P/D multiplier,
// saturating at every narrowing step. Define PID_INTEG_EN to include the integrator path.
module balance_pid_seq #(
    parameter logic [4:0] P_COEF   = 5'd9,
    parameter logic [5:0] D_COEF   = 6'd20,
    parameter int         D_QDEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic               pwr_up,
    input  logic               cntrl_rdy,
    output logic signed [11:0] PID_cntrl,
    output logic               cntrl_vld,
    output logic               smpl_drop
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SAT   = 3'd1,
        PTERM = 3'd2,
        DTERM = 3'd3,
`ifdef PID_INTEG_EN
        ITERM = 3'd4,
`endif
        SUM   = 3'd5,
        HOLD  = 3'd6
    } state_t;

    state_t             state_q;
    logic signed [15:0] ptch_q;
    logic signed [9:0]  err_sat_q;
    logic signed [9:0]  err_sat_d;
    logic signed [14:0] p_term_q;
    logic signed [14:0] p_term_d;
    logic signed [12:0] d_term_q;
    logic signed [12:0] d_term_d;
    logic signed [11:0] pid_q;
    logic signed [11:0] pid_d;
    logic               cntrl_vld_q;
    logic               smpl_drop_q;
    logic signed [9:0]  hist_q [D_QDEPTH];

    logic signed [10:0] d_diff;
    logic signed [6:0]  d_diff_sat;
    logic signed [9:0]  mult_a;
    logic signed [6:0]  mult_b;
    logic signed [16:0] product;
    logic signed [11:0] i_term;
    logic signed [15:0] total;

    always_comb begin
        err_sat_d = ptch_q[9:0];
        if (ptch_q > 16'sd511)
            err_sat_d = 10'sh1FF;
        else if (ptch_q < -16'sd512)
            err_sat_d = 10'sh200;
    end

    // hist_q[D_QDEPTH-1] is the oldest processed sample
    always_comb begin
        d_diff = {err_sat_q[9], err_sat_q} - {hist_q[D_QDEPTH-1][9], hist_q[D_QDEPTH-1]};
        d_diff_sat = d_diff[6:0];
        if (d_diff > 11'sd63)
            d_diff_sat = 7'sh3F;
        else if (d_diff < -11'sd64)
            d_diff_sat = 7'sh40;
    end

    // Single multiplier: P operand in PTERM, D operand otherwise
    always_comb begin
        if (state_q == PTERM) begin
            mult_a = err_sat_q;
            mult_b = {2'b00, P_COEF};
        end else begin
            mult_a = {{3{d_diff_sat[6]}}, d_diff_sat};
            mult_b = {1'b0, D_COEF};
        end
        product = mult_a * mult_b;
    end

    always_comb begin
        p_term_d = product[14:0];
        if (product > 17'sd16383)
            p_term_d = 15'sh3FFF;
        else if (product < -17'sd16384)
            p_term_d = 15'sh4000;
        d_term_d = product[12:0];
        if (product > 17'sd4095)
            d_term_d = 13'sh0FFF;
        else if (product < -17'sd4096)
            d_term_d = 13'sh1000;
    end

`ifdef PID_INTEG_EN
    logic signed [17:0] integ_q;
    logic signed [17:0] integ_sum;
    logic               integ_ovf;

    assign integ_sum = integ_q + {{8{err_sat_q[9]}}, err_sat_q};
    assign integ_ovf = (integ_q[17] == err_sat_q[9]) && (integ_sum[17] != integ_q[17]);
    assign i_term    = integ_q[17:6];

    always_ff @(posedge clk) begin
        if (rst || !pwr_up)
            integ_q <= '0;
        else if (state_q == ITERM && !integ_ovf)
            integ_q <= integ_sum;
    end
`else
    logic unused_pwr_up;
    assign unused_pwr_up = pwr_up;
    assign i_term        = '0;
`endif

    always_comb begin
        total = {{4{i_term[11]}}, i_term} + {p_term_q[14], p_term_q}
              + {{3{d_term_q[12]}}, d_term_q};
        pid_d = total[11:0];
        if (total > 16'sd2047)
            pid_d = 12'sh7FF;
        else if (total < -16'sd2048)
            pid_d = 12'sh800;
    end

    // Derivative history shifts once per processed sample, during DTERM
    genvar gi;
    generate
        for (gi = 0; gi < D_QDEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst)
                        hist_q[0] <= '0;
                    else if (state_q == DTERM)
                        hist_q[0] <= err_sat_q;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst)
                        hist_q[gi] <= '0;
                    else if (state_q == DTERM)
                        hist_q[gi] <= hist_q[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptch_q      <= '0;
            err_sat_q   <= '0;
            p_term_q    <= '0;
            d_term_q    <= '0;
            pid_q       <= '0;
            cntrl_vld_q <= 1'b0;
            smpl_drop_q <= 1'b0;
        end else begin
            smpl_drop_q <= vld && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (vld) begin
                        ptch_q  <= ptch;
                        state_q <= SAT;
                    end
                end
                SAT: begin
                    err_sat_q <= err_sat_d;
                    state_q   <= PTERM;
                end
                PTERM: begin
                    p_term_q <= p_term_d;
                    state_q  <= DTERM;
                end
                DTERM: begin
                    d_term_q <= d_term_d;
`ifdef PID_INTEG_EN
                    state_q  <= ITERM;
`else
                    state_q  <= SUM;
`endif
                end
`ifdef PID_INTEG_EN
                ITERM: begin
                    state_q <= SUM;
                end
`endif
                SUM: begin
                    pid_q       <= pid_d;
                    cntrl_vld_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (cntrl_rdy) begin
                        cntrl_vld_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PID_cntrl = pid_q;
    assign cntrl_vld = cntrl_vld_q;
    assign smpl_drop = smpl_drop_q;

endmodule

// File: tb/tb_balance_pid_seq.sv
// Self-checking bench for balance_pid_seq: directed vector table, corner sequences,
// and randomized samples against an arithmetic reference model.
module tb_balance_pid_seq;

`ifdef PID_INTEG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [15:0] ptch;
    logic        pwr_up;
    logic        cntrl_rdy;
    logic [11:0] PID_cntrl;
    logic        cntrl_vld;
    logic        smpl_drop;

    int n_checks = 0;
    int n_fail   = 0;

    int hist_m[$];
    int integ_m;

    balance_pid_seq dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .ptch      (ptch),
        .pwr_up    (pwr_up),
        .cntrl_rdy (cntrl_rdy),
        .PID_cntrl (PID_cntrl),
        .cntrl_vld (cntrl_vld),
        .smpl_drop (smpl_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_reset();
        hist_m.delete();
        for (int i = 0; i < 2; i++) hist_m.push_back(0);
        integ_m = 0;
    endfunction

    // Control law from the arithmetic rules: gains 9 and 20, history depth 2
    function automatic int model_step(input logic [15:0] p, input bit pw);
        int e, oldest, d, i_t, s;
        e = clamp(int'($signed(p)), -512, 511);
        oldest = hist_m.pop_front();
        hist_m.push_back(e);
        d = clamp(e - oldest, -64, 63);
`ifdef PID_INTEG_EN
        if (!pw) integ_m = 0;
        else begin
            s = integ_m + e;
            if (s >= -131072 && s <= 131071) integ_m = s;
        end
        i_t = integ_m >>> 6;
`else
        s = 0;
        i_t = pw ? s : 0;
`endif
        return clamp(e * 9 + d * 20 + i_t, -2048, 2047);
    endfunction

    task automatic do_reset();
        rst = 1'b1; vld = 1'b0; cntrl_rdy = 1'b0; pwr_up = 1'b1; ptch = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Assumes FSM idle and called at posedge+1
    task automatic run_sample(input logic [15:0] p, input bit pw, input int stall,
                              input int drop_at, input bit drop_exit, input int exp_pid,
                              input string name);
        bit early = 0;
        bit unstable = 0;
        int held;
        ptch = p; pwr_up = pw; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk); #1;
            if (i < LAT && cntrl_vld) early = 1;
        end
        chk($sformatf("%s_early", name), int'(early), 0);
        chk($sformatf("%s_vld", name), int'(cntrl_vld), 1);
        chk($sformatf("%s_pid", name), int'($signed(PID_cntrl)), exp_pid);
        held = int'($signed(PID_cntrl));
        for (int c = 0; c < stall; c++) begin
            if (c == drop_at) begin vld = 1'b1; ptch = 16'h4321; end
            @(posedge clk); #1;
            vld = 1'b0;
            if (c == drop_at) chk($sformatf("%s_drop", name), int'(smpl_drop), 1);
            else if (c == drop_at + 1) chk($sformatf("%s_drop_end", name), int'(smpl_drop), 0);
            if (cntrl_vld !== 1'b1 || int'($signed(PID_cntrl)) != held) unstable = 1;
        end
        if (stall > 0) chk($sformatf("%s_stable", name), int'(unstable), 0);
        cntrl_rdy = 1'b1;
        if (drop_exit) begin vld = 1'b1; ptch = 16'h2222; end
        @(posedge clk); #1;
        cntrl_rdy = 1'b0; vld = 1'b0;
        chk($sformatf("%s_exit", name), int'(cntrl_vld), 0);
        if (drop_exit) chk($sformatf("%s_exit_drop", name), int'(smpl_drop), 1);
    endtask

    typedef struct {
        logic [15:0] p;
        bit          pw;
        int          exp_pid;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   e;
        bit   bad;
        logic [15:0] rp;
        bit   rpw;

        vecs[0] = '{16'h0010, 1'b1,   464};
        vecs[1] = '{16'h8000, 1'b1, -2048};
        vecs[2] = '{16'h7FFF, 1'b1,  2047};
        vecs[3] = '{16'hFFFD, 1'b1,  1233};
        vecs[4] = '{16'h0014, 1'b1, -1100};
        vecs[5] = '{16'hFFFB, 1'b1,   -85};
        vecs[6] = '{16'hFFFB, 1'b0,  -545};

        do_reset();
        chk("reset_pid", int'($signed(PID_cntrl)), 0);
        chk("reset_vld", int'(cntrl_vld), 0);
        chk("reset_drop", int'(smpl_drop), 0);

        for (int i = 0; i < 7; i++) begin
            e = model_step(vecs[i].p, vecs[i].pw);
            run_sample(vecs[i].p, vecs[i].pw, 0, -1, 1'b0, vecs[i].exp_pid,
                       $sformatf("vec%0d", i));
            $display("vec%0d ptch=%h pid=%0d", i, vecs[i].p, int'($signed(PID_cntrl)));
        end

        // Long stall with a dropped sample inside HOLD; history must be untouched
        e = model_step(16'h0040, 1'b1);
        run_sample(16'h0040, 1'b1, 10, 4, 1'b0, e, "hold_stall");
        e = model_step(16'h0040, 1'b1);
        run_sample(16'h0040, 1'b1, 0, -1, 1'b1, e, "after_stall");
        e = model_step(16'hFF00, 1'b1);
        run_sample(16'hFF00, 1'b1, 0, -1, 1'b0, e, "after_exit_drop");

        // Integrator saturation run
        do_reset();
        for (int i = 0; i < 257; i++) begin
            e = model_step(16'h01FF, 1'b1);
            run_sample(16'h01FF, 1'b1, 0, -1, 1'b0, e, $sformatf("integ%0d", i));
        end
        e = model_step(16'h0000, 1'b1);
        run_sample(16'h0000, 1'b1, 0, -1, 1'b0, e, "integ_probe");
`ifdef PID_INTEG_EN
        chk("integ_hold_value", int'($signed(PID_cntrl)), 764);
`else
        chk("integ_hold_value", int'($signed(PID_cntrl)), -1280);
`endif
        $display("integ_probe pid=%0d", int'($signed(PID_cntrl)));

        // Reset landing while the sequence is in DTERM
        ptch = 16'h0123; vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("rst_mid_vld", int'(cntrl_vld), 0);
        chk("rst_mid_pid", int'($signed(PID_cntrl)), 0);
        bad = 0;
        repeat (LAT + 2) begin
            @(posedge clk); #1;
            if (cntrl_vld) bad = 1;
        end
        chk("rst_mid_quiet", int'(bad), 0);
        e = model_step(16'h0010, 1'b1);
        chk("rst_mid_model", e, 464);
        run_sample(16'h0010, 1'b1, 0, -1, 1'b0, 464, "rst_mid_next");
        $display("rst_mid_next pid=%0d", int'($signed(PID_cntrl)));

        // Randomized samples
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) rp = 16'($urandom);
            else rp = 16'($urandom_range(0, 1400)) - 16'd700;
            rpw = ($urandom_range(0, 7) != 0);
            e = model_step(rp, rpw);
            run_sample(rp, rpw, int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)), e,
                       $sformatf("rand%0d", i));
            $display("rand%0d ptch=%h pwr=%0d pid=%0d exp=%0d", i, rp, rpw,
                     int'($signed(PID_cntrl)), e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
